// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU fetch-path state encoding and next-PC mux selects
package ppu_pkg;
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      DSLOT = 2'd3
   } state_t;
   localparam logic [1:0] NPC_SEQ  = 2'd0;
   localparam logic [1:0] NPC_TGT  = 2'd1;
   localparam logic [1:0] NPC_HOLD = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with async reset and sync clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count
);
   // count enabled cycles, sticking at all-ones
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clear) count <= '0;
      else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC front/back sequencing FSM (boot hold, stalls, delayed branches); PC_SEQ_CTRL_PERF_EN adds counters
module pc_seq_ctrl
   import ppu_pkg::*;
#(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic             br_nullify,
   output logic             pc_le,
   output logic [1:0]       npc_sel,
   output logic             ifid_le,
   output logic             ifid_nullify,
   output logic             busy_boot,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] br_cnt
);
   localparam int BOOT_LAST = (BOOT_CYCLES < 2) ? 0 : BOOT_CYCLES - 1;
   localparam int BW = $clog2(BOOT_LAST + 2);
   localparam logic [BW-1:0] BOOT_END = BW'(BOOT_LAST);
   state_t state, nxt;
   logic [BW-1:0] boot_cnt;
   logic nflag, accept;
   // state, boot counter and delay-slot nullify flag
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= BOOT;
         boot_cnt <= '0;
         nflag    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == BOOT) boot_cnt <= boot_cnt + 1'b1;
         if (accept) nflag <= br_nullify;
      end
   // next state and output decode; STALL with stall low behaves exactly as RUN
   always_comb begin
      nxt          = state;
      pc_le        = 1'b0;
      npc_sel      = NPC_HOLD;
      ifid_le      = 1'b0;
      ifid_nullify = 1'b0;
      busy_boot    = 1'b0;
      accept       = 1'b0;
      case (state)
         BOOT: begin
            ifid_nullify = 1'b1;
            busy_boot    = 1'b1;
            if (boot_cnt == BOOT_END) nxt = RUN;
         end
         RUN, STALL: begin
            if (stall) nxt = STALL;
            else begin
               pc_le   = 1'b1;
               ifid_le = 1'b1;
               accept  = br_taken;
               npc_sel = br_taken ? NPC_TGT : NPC_SEQ;
               nxt     = br_taken ? DSLOT : RUN;
            end
         end
         DSLOT: begin
            ifid_nullify = nflag;
            if (!stall) begin
               pc_le   = 1'b1;
               ifid_le = 1'b1;
               npc_sel = NPC_SEQ;
               nxt     = RUN;
            end
         end
      endcase
   end
`ifdef PC_SEQ_CTRL_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .en    (state != BOOT && !pc_le),
      .count (stall_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .en    (accept),
      .count (br_cnt)
   );
`else
   assign stall_cnt = '0;
   assign br_cnt    = '0;
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: table-driven check of pc_seq_ctrl outputs plus async-reset corner case
module tb_pc_seq_ctrl;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, br_taken = 1'b0, br_nullify = 1'b0;
   logic pc_le, ifid_le, ifid_nullify, busy_boot;
   logic [1:0] npc_sel;
   logic [15:0] stall_cnt, br_cnt;
   int total = 0, passed = 0;

   pc_seq_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_nullify(br_nullify),
      .pc_le(pc_le), .npc_sel(npc_sel), .ifid_le(ifid_le), .ifid_nullify(ifid_nullify),
      .busy_boot(busy_boot), .stall_cnt(stall_cnt), .br_cnt(br_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic st, bt, bn;
      logic le;
      logic [1:0] sel;
      logic il, in, bb;
   } vec_t;

   vec_t v[23];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic check_outs(input string tag, input logic le, input logic [1:0] sel,
                             input logic il, input logic in, input logic bb);
      check({tag, ".pc_le"}, {15'd0, pc_le}, {15'd0, le});
      check({tag, ".npc_sel"}, {14'd0, npc_sel}, {14'd0, sel});
      check({tag, ".ifid_le"}, {15'd0, ifid_le}, {15'd0, il});
      check({tag, ".ifid_nullify"}, {15'd0, ifid_nullify}, {15'd0, in});
      check({tag, ".busy_boot"}, {15'd0, busy_boot}, {15'd0, bb});
   endtask

   task automatic drive(input logic s, input logic b, input logic n);
      @(negedge clk);
      stall = s; br_taken = b; br_nullify = n;
      #1;
   endtask

   initial begin
      //        st    bt    bn    le    sel   il    in    bb
      v[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
      v[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
      v[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      v[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      v[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      v[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
      v[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
      v[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
      v[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      v[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      v[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
      v[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      v[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
      v[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
      v[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
      v[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
      v[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
      check("reset.stall_cnt", stall_cnt, 16'd0);
      check("reset.br_cnt", br_cnt, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 23; i++) begin
         if (i > 0) @(negedge clk);
         stall = v[i].st; br_taken = v[i].bt; br_nullify = v[i].bn;
         #1;
         check_outs($sformatf("vec%0d", i), v[i].le, v[i].sel, v[i].il, v[i].in, v[i].bb);
      end

      drive(1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_CTRL_PERF_EN
      check("stall_cnt", stall_cnt, 16'd7);
      check("br_cnt", br_cnt, 16'd4);
`else
      check("stall_cnt", stall_cnt, 16'd0);
      check("br_cnt", br_cnt, 16'd0);
`endif

      drive(1'b0, 1'b1, 1'b1);
      check_outs("mid.branch", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check_outs("mid.dslot", 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_outs("async_rst", 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
      check("async_rst.stall_cnt", stall_cnt, 16'd0);
      check("async_rst.br_cnt", br_cnt, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_outs("reboot0", 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check_outs("reboot1", 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      check_outs("post.branch", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check_outs("post.dslot", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
